pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32: payload width in bits; legal range 1..512.
REQ-002 SHALL have parameter CNT_W, default 16: stall-counter width in bits; legal range 4..32.
REQ-003 SHALL have parameter CLEAR_ON_FLUSH, default 1: 1 zeroes the payload registers on flush, 0 holds them.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  synchronous bubble insert; discards all held entries.
REQ-007 SHALL have port in_valid  input  1  upstream entry present.
REQ-008 SHALL have port in_ready  output  1  stage accepts an entry this cycle.
REQ-009 SHALL have port in_data  input  DATA_W  upstream payload (packed stage struct).
REQ-010 SHALL have port out_valid  output  1  downstream entry present.
REQ-011 SHALL have port out_ready  input  1  downstream consumes this cycle.
REQ-012 SHALL have port out_data  output  DATA_W  registered payload to the next stage.
REQ-013 SHALL have port stall_cnt  output  CNT_W  saturating count of back-pressured cycles.

Function
REQ-014 Transfer in SHALL occur when in_valid and in_ready are both 1; transfer out SHALL occur when out_valid and out_ready are both 1.
REQ-015 out_data and out_valid SHALL be driven directly from flops; no combinational path from in_data to out_data.
REQ-016 Latency SHALL be one cycle: an entry accepted at edge N is presented on out_data after edge N.
REQ-017 Entries SHALL leave in acceptance order; no entry SHALL be duplicated or dropped except by flush or reset.
REQ-018 out_data SHALL remain stable while out_valid is 1 and out_ready is 0.
REQ-019 Simultaneous transfer in and out in the same cycle SHALL be supported at full throughput (one entry per cycle).
REQ-020 flush SHALL take priority over all transfers: on the flush edge, every valid flag clears, any in_data offered that cycle is dropped, and in_ready is 1 on the following cycle.
REQ-021 With CLEAR_ON_FLUSH=1, flush SHALL zero out_data (and skid payload); with 0, payload registers SHALL hold their value.
REQ-022 stall_cnt SHALL increment by 1 on each edge where out_valid is 1 and out_ready is 0, SHALL saturate at 2^CNT_W-1, and SHALL NOT be cleared by flush.
REQ-023 in_valid with in_ready 0 SHALL have no effect on state; upstream SHALL hold in_data until accepted.

Reset
REQ-024 On reset, out_valid SHALL be 0, in_ready SHALL be 1 on the next cycle, out_data SHALL be 0, stall_cnt SHALL be 0, and the skid state (when compiled) SHALL be EMPTY.
REQ-025 reset SHALL take priority over flush and all transfers; reset mid-transfer SHALL discard all held entries.

Configuration
REQ-026 Macro PIPE_STAGE_REG_SKID_EN SHALL select the buffering structure.
REQ-027 Without the macro: single register; in_ready SHALL equal (not out_valid) or out_ready (combinational from out_ready).
REQ-028 With the macro: main register plus one skid register; in_ready SHALL be a flop output equal to "skid register empty", with no combinational path from out_ready.
REQ-029 With the macro, the state machine SHALL use states EMPTY (0 held), ONE (main valid), FULL (main and skid valid): EMPTY->ONE on in only; ONE->EMPTY on out only; ONE->FULL on in without out; FULL->ONE on out (skid moves to main, in_ready was 0); all other cases hold; flush/reset force EMPTY.

Verification
REQ-030 Stream 0x11,0x22,0x33 with out_ready=1 held -> out_data 0x11,0x22,0x33 on consecutive cycles, one cycle after each accept, stall_cnt=0.
REQ-031 Load 0xAA, hold out_ready=0 for 5 cycles -> out_data stays 0xAA, stall_cnt=5; with skid, a second entry 0xBB is accepted, then in_ready=0.
REQ-032 Skid build, FULL (0xAA main, 0xBB skid), release out_ready -> 0xAA then 0xBB out, in_ready returns 1 after 0xAA leaves, no loss.
REQ-033 Flush asserted with out_valid=1 and in_valid=1 (0xCC) -> next cycle out_valid=0, 0xCC never appears, out_data=0 (CLEAR_ON_FLUSH=1), stall_cnt unchanged.
REQ-034 CNT_W=4, out_ready=0 for 20 cycles with out_valid=1 -> stall_cnt saturates at 15.
REQ-035 reset asserted while FULL -> next cycle out_valid=0, out_data=0, stall_cnt=0, in_ready=1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage: one registered entry, or main plus skid register when PIPE_STAGE_REG_SKID_EN is defined.
// Latency one cycle; backpressure holds out_data stable and counts stalled cycles in a saturating counter.
module pipe_stage_reg #(
    parameter int DATA_W         = 32,
    parameter int CNT_W          = 16,
    parameter int CLEAR_ON_FLUSH = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              valid_q;
    logic [DATA_W-1:0] main_q;
    logic              out_fire;

    assign out_valid = valid_q;
    assign out_data  = main_q;
    assign out_fire  = valid_q & out_ready;

`ifdef PIPE_STAGE_REG_SKID_EN

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic              ready_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_fire;

    // in_ready is a pure flop so out_ready never reaches the upstream handshake.
    assign in_ready = ready_q;
    assign in_fire  = in_valid & ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            if (CLEAR_ON_FLUSH != 0) begin
                main_q <= '0;
                skid_q <= '0;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_q  <= in_data;
                        valid_q <= 1'b1;
                        state   <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        skid_q  <= in_data;
                        ready_q <= 1'b0;
                        state   <= FULL;
                    end else if (out_fire) begin
                        valid_q <= 1'b0;
                        state   <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_q  <= skid_q;
                        ready_q <= 1'b1;
                        state   <= ONE;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

`else

    logic in_fire;

    // Accept when the register is empty or is being drained this same cycle.
    assign in_ready = ~valid_q | out_ready;
    assign in_fire  = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            main_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            if (CLEAR_ON_FLUSH != 0) begin
                main_q <= '0;
            end
        end else if (in_fire) begin
            valid_q <= 1'b1;
            main_q  <= in_data;
        end else if (out_fire) begin
            valid_q <= 1'b0;
        end
    end

`endif

    // Stall history survives flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (valid_q && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
